register_read_sequencer: RTL
============================

Name: register_read_sequencer

Overview:
- Read-side counterpart to the team's 8-bit and 16-bit load-enabled registers.
- Accepts a read request naming one 8-bit or one 16-bit register.
- Snapshots the selected value and streams it as byte beats onto an 8-bit data path under a valid/ready handshake.
- Sits between the register bank outputs and the CPU's 8-bit internal data bus / debug readout.

Parameters:
- NUM8, 4, number of 8-bit source registers on reg8_flat.
- NUM16, 2, number of 16-bit source registers on reg16_flat.
- SEL_W, 2, width of rd_sel; must satisfy 2**SEL_W >= max(NUM8, NUM16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- reg8_flat  input  NUM8*8  8-bit register outputs, reg i at [8i+7:8i].
- reg16_flat  input  NUM16*16  16-bit register outputs, reg i at [16i+15:16i].
- rd_req  input  1  read request.
- rd_wide  input  1  0 = 8-bit source, 1 = 16-bit source; sampled with rd_req.
- rd_sel  input  SEL_W  source index; sampled with rd_req.
- rd_ready  output  1  request can be accepted this cycle.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  8  beat data.
- out_last  output  1  final beat of the current read.
- out_err  output  1  current read selected an out-of-range index.

Behaviour:
- Reset (clk edge with reset==0) values: out_valid=0, out_data=8'h00, out_last=0, out_err=0, snapshot=16'h0000, state=IDLE. rd_ready=0 while reset is low.
- FSM states: IDLE, BEAT0, BEAT1.
- rd_ready=1 only in IDLE with reset high. Accept = rd_req && rd_ready.
- IDLE, on accept:
  - Capture the selected value into the 16-bit snapshot (8-bit sources zero-extended).
  - Latch wide = rd_wide and err = out-of-range.
  - Go to BEAT0. Source changes after the accept edge do not affect the read.
- Out of range: rd_wide=0 with rd_sel>=NUM8, or rd_wide=1 with rd_sel>=NUM16.
  - Snapshot = 0.
  - Normal beat count still issued (1 beat narrow, 2 beats wide).
  - out_err=1 on every beat.
- BEAT0: out_valid=1; out_data = snapshot[7:0]; out_last = !wide; out_err = err.
  - On out_valid && out_ready: wide → BEAT1, else → IDLE.
- BEAT1: out_valid=1; out_data = snapshot[15:8]; out_last=1; out_err = err.
  - On out_valid && out_ready → IDLE.
- Outputs are registered.
  - First beat is valid in the cycle after accept (latency 1).
  - out_data, out_last and out_err stay stable while out_valid && !out_ready (no drop, no change).
- After the final transfer, out_valid=0 and rd_ready=1 in the next cycle. There is no same-cycle accept-on-last.
  - Minimum period: 2 cycles per narrow read, 3 cycles per wide read.
- rd_req while rd_ready=0 is ignored; no queuing.
- out_ready while out_valid=0 has no effect.
- reset low mid-read: the read is aborted in that cycle and no remaining beat is emitted. The consumer sees out_valid fall with no out_last.
- rd_sel and rd_wide are don't-care when rd_req=0.

Optional Feature:
- Macro: REG_READ_HI_FIRST_EN.
- Defined: wide reads emit snapshot[15:8] in BEAT0 and snapshot[7:0] in BEAT1 (big-endian). Narrow reads are unchanged.
- Undefined: low byte first, as described above.
- Width, handshake and latency are identical in both builds.

Test Plan:
- Narrow read: reg8_flat=32'hDDCC_BBAA, rd_req=1, rd_wide=0, rd_sel=2, out_ready=1 → next cycle out_valid=1, out_data=8'hCC, out_last=1, out_err=0. rd_ready=1 one cycle later.
- Wide read with backpressure: reg16_flat[31:16]=16'hBEEF, rd_sel=1, rd_wide=1, out_ready=0 for 3 cycles → out_data holds 8'hEF with out_last=0 throughout. Then out_ready=1 → 8'hEF, then 8'hBE with out_last=1. With REG_READ_HI_FIRST_EN defined: 8'hBE then 8'hEF.
- Snapshot: accept a wide read of 16'h1234, then change the source to 16'hFFFF the next cycle → beats are 8'h34, 8'h12.
- Out of range: NUM16=2, rd_wide=1, rd_sel=3 → two beats of 8'h00 with out_err=1 on both, out_last=1 on the second. NUM8=4, rd_wide=0, rd_sel=3 is in range → out_err=0.
- Busy ignore: hold rd_req=1 throughout a wide read → exactly one read is performed per IDLE visit, and rd_ready=0 during BEAT0/BEAT1.
- Reset mid-read: assert reset=0 during BEAT1 with out_ready=0 → next cycle out_valid=0, out_data=8'h00, rd_ready=0. After releasing reset, rd_ready=1 and no stale beat appears.

Source files
------------

// File: rtl/register_read_sequencer.sv
// register_read_sequencer
// Read-side companion to the 8-bit and 16-bit load-enabled registers. A read
// request snapshots one 8-bit or 16-bit source. The snapshot is streamed as
// byte beats on an 8-bit valid/ready path: one beat for narrow reads, two beats
// for wide reads.
//
// Optional build macro REG_READ_HI_FIRST_EN:
//   defined   -> wide reads emit the high byte first (big-endian beat order)
//   undefined -> wide reads emit the low byte first
//
// The snapshot register holds the bytes in emission order, and its low byte
// drives out_data directly. Advancing to the second beat shifts the high byte
// down, so out_data is always a flop output with no output-side mux.
module register_read_sequencer #(
  parameter int NUM8  = 4,
  parameter int NUM16 = 2,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM8*8-1:0]     reg8_flat,
  input  logic [NUM16*16-1:0]   reg16_flat,
  input  logic                  rd_req,
  input  logic                  rd_wide,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic                  rd_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  out_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;

  logic [1:0]  state;
  logic [15:0] snapshot;
  logic        wide;

  logic [31:0] sel_ext;
  logic [7:0]  val8;
  logic [15:0] val16;
  logic        sel_err;
  logic [15:0] src_val;
  logic [15:0] first_order;
  logic        accept;

  assign sel_ext  = 32'(rd_sel);
  assign rd_ready = (state == IDLE) && reset;
  assign accept   = rd_req && rd_ready;
  assign out_data = snapshot[7:0];

  // Select the addressed source; out-of-range indices read as zero and flag an error.
  always_comb begin
    val8  = 8'h00;
    val16 = 16'h0000;
    for (int i = 0; i < NUM8; i++) begin
      if (sel_ext == 32'(i)) val8 = reg8_flat[8*i +: 8];
    end
    for (int j = 0; j < NUM16; j++) begin
      if (sel_ext == 32'(j)) val16 = reg16_flat[16*j +: 16];
    end
    if (rd_wide) sel_err = (sel_ext >= 32'(NUM16));
    else         sel_err = (sel_ext >= 32'(NUM8));
    if (sel_err)      src_val = 16'h0000;
    else if (rd_wide) src_val = val16;
    else              src_val = {8'h00, val8};
`ifdef REG_READ_HI_FIRST_EN
    if (rd_wide) first_order = {src_val[7:0], src_val[15:8]};
    else         first_order = src_val;
`else
    first_order = src_val;
`endif
  end

  // Read FSM: capture on accept, then hold each beat until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      snapshot  <= 16'h0000;
      wide      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BEAT0;
            snapshot  <= first_order;
            wide      <= rd_wide;
            out_valid <= 1'b1;
            out_last  <= !rd_wide;
            out_err   <= sel_err;
          end
        end
        BEAT0: begin
          if (out_ready) begin
            if (wide) begin
              state    <= BEAT1;
              snapshot <= {8'h00, snapshot[15:8]};
              out_last <= 1'b1;
            end else begin
              state     <= IDLE;
              snapshot  <= 16'h0000;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_err   <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (out_ready) begin
            state     <= IDLE;
            snapshot  <= 16'h0000;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          snapshot  <= 16'h0000;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
